// File: rtl/pixel_filter_pipe.sv
// rtl/pixel_filter_pipe.sv - two-stage valid/ready pixel filter: pass, brightness, box blur, zero
// Mode switches are latched on start-of-line beats only so a line is never filtered two ways.
module pixel_filter_pipe #(
   parameter int CH_W      = 8,
   parameter int NUM_CH    = 4,
   parameter int BLUR_TAPS = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_CH*CH_W-1:0] in_data,
   input  logic                   in_sol,
   input  logic [1:0]             mode_req,
   input  logic [CH_W-1:0]        beta,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_CH*CH_W-1:0] out_data,
   output logic                   out_sol,
   output logic [1:0]             active_mode,
   output logic                   mode_pending
);
   localparam int PIX_W  = NUM_CH * CH_W;
   localparam int SH     = $clog2(BLUR_TAPS);
   localparam int SUM_W  = CH_W + SH;
   localparam int HIST_N = BLUR_TAPS - 1;

   logic              advance;
   logic              accept;
   logic [1:0]        applied_mode;
   logic [PIX_W-1:0]  hist [HIST_N];
   logic [SUM_W-1:0]  acc;
   logic [PIX_W-1:0]  avg;

   logic              s1_valid;
   logic [PIX_W-1:0]  s1_data;
   logic              s1_sol;
   logic [1:0]        s1_mode;
   logic [CH_W-1:0]   s1_beta;
   logic [PIX_W-1:0]  s1_avg;

   logic [PIX_W-1:0]  result;
   logic [CH_W+1:0]   bsum;

   assign advance      = out_ready | ~out_valid;
   assign in_ready     = advance;
   assign accept       = in_valid & advance;
   assign applied_mode = in_sol ? mode_req : active_mode;
   assign mode_pending = (mode_req != active_mode);

   // A start-of-line beat sees its own pixel replicated across the whole window.
   always_comb begin
      acc = '0;
      avg = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         acc = SUM_W'(in_data[c*CH_W +: CH_W]);
         for (int t = 0; t < HIST_N; t++)
            acc = acc + SUM_W'(in_sol ? in_data[c*CH_W +: CH_W] : hist[t][c*CH_W +: CH_W]);
         avg[c*CH_W +: CH_W] = acc[SUM_W-1:SH];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < HIST_N; i++)
            hist[i] <= '0;
      end else if (accept) begin
         if (in_sol) begin
            for (int i = 0; i < HIST_N; i++)
               hist[i] <= in_data;
         end else begin
            hist[0] <= in_data;
            for (int i = 1; i < HIST_N; i++)
               hist[i] <= hist[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         active_mode <= 2'b00;
      else if (accept && in_sol)
         active_mode <= mode_req;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_sol   <= 1'b0;
         s1_mode  <= 2'b00;
         s1_beta  <= '0;
         s1_avg   <= '0;
      end else if (advance) begin
         s1_valid <= accept;
         if (accept) begin
            s1_data <= in_data;
            s1_sol  <= in_sol;
            s1_mode <= applied_mode;
            s1_beta <= beta;
            s1_avg  <= avg;
         end
      end
   end

   // Brightness uses two guard bits: bit CH_W+1 flags underflow, bit CH_W overflow.
   always_comb begin
      result = '0;
      bsum   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         case (s1_mode)
            2'b00: result[c*CH_W +: CH_W] = s1_data[c*CH_W +: CH_W];
            2'b01: begin
               bsum = {2'b00, s1_data[c*CH_W +: CH_W]} + {{2{s1_beta[CH_W-1]}}, s1_beta};
               if (bsum[CH_W+1])
                  result[c*CH_W +: CH_W] = '0;
               else if (bsum[CH_W])
                  result[c*CH_W +: CH_W] = {CH_W{1'b1}};
               else
                  result[c*CH_W +: CH_W] = bsum[CH_W-1:0];
            end
            2'b10:   result[c*CH_W +: CH_W] = s1_avg[c*CH_W +: CH_W];
            default: result[c*CH_W +: CH_W] = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sol   <= 1'b0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= result;
            out_sol  <= s1_sol;
         end
      end
   end
endmodule

// File: tb/tb_pixel_filter_pipe.sv
// tb/tb_pixel_filter_pipe.sv - table-driven scoreboard bench for pixel_filter_pipe
module tb_pixel_filter_pipe;
   localparam int CH_W = 8;
   localparam int NUM_CH = 4;
   localparam int BLUR_TAPS = 4;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_sol;
   logic [1:0]  mode_req;
   logic [7:0]  beta;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_sol;
   logic [1:0]  active_mode;
   logic        mode_pending;

   pixel_filter_pipe #(.CH_W(CH_W), .NUM_CH(NUM_CH), .BLUR_TAPS(BLUR_TAPS)) dut (
      .clk(clk), .n_rst(n_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sol(in_sol),
      .mode_req(mode_req), .beta(beta),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sol(out_sol),
      .active_mode(active_mode), .mode_pending(mode_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        sol;
      logic [1:0]  mode;
      logic [7:0]  beta;
      logic [31:0] exp;
      logic        pend;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        sol;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   in_cnt = 0;
   int   out_cnt = 0;
   logic bp_en = 1'b0;
   logic ready_force = 1'b1;
   logic stalled = 1'b0;
   logic [31:0] hold_data;
   logic        hold_sol;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic void add_vec(logic [31:0] d, logic s, logic [1:0] m, logic [7:0] b,
                                   logic [31:0] e, logic p);
      vec_t v;
      v.data = d; v.sol = s; v.mode = m; v.beta = b; v.exp = e; v.pend = p;
      vecs.push_back(v);
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_force;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!n_rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, hold_data);
            check("stall_sol", 32'(out_sol), 32'(hold_sol));
         end
         if (out_valid && out_ready) begin
            out_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %h expected none", out_data);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_sol", 32'(out_sol), 32'(e.sol));
            end
         end
         stalled   = out_valid && !out_ready;
         hold_data = out_data;
         hold_sol  = out_sol;
      end
   end

   task automatic send(input vec_t v, input string tag);
      int   waited = 0;
      exp_t e;
      in_data = v.data; in_sol = v.sol; mode_req = v.mode; beta = v.beta; in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_pending"}, 32'(mode_pending), 32'(v.pend));
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: got in_ready=0 expected 1 within 200 cycles", tag);
      end else begin
         e.data = v.exp;
         e.sol  = v.sol;
         sb.push_back(e);
         in_cnt++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int w = 0;
      while (sb.size() > 0 && w < 500) begin
         @(posedge clk);
         w++;
      end
      #1;
      check({tag, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_active_mode", 32'(active_mode), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish before 500us");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

   initial begin
      int saved;
      n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sol = 1'b0; mode_req = 2'b00; beta = '0;

      add_vec(32'h11223344, 1, 2'b00, 8'h00, 32'h11223344, 0);
      add_vec(32'h004010F0, 1, 2'b01, 8'h20, 32'h206030FF, 1);
      add_vec(32'h7F408010, 0, 2'b01, 8'hE0, 32'h5F206000, 0);
      add_vec(32'hFF002040, 0, 2'b01, 8'h05, 32'hFF052545, 0);
      add_vec(32'h04040404, 1, 2'b10, 8'h00, 32'h04040404, 1);
      add_vec(32'h08080808, 0, 2'b10, 8'h00, 32'h05050505, 0);
      add_vec(32'h0C0C0C0C, 0, 2'b10, 8'h00, 32'h07070707, 0);
      add_vec(32'h10101010, 0, 2'b10, 8'h00, 32'h0A0A0A0A, 0);
      add_vec(32'h14141414, 0, 2'b10, 8'h00, 32'h0E0E0E0E, 0);
      add_vec(32'h64646464, 1, 2'b10, 8'h00, 32'h64646464, 0);
      add_vec(32'h00000000, 0, 2'b10, 8'h00, 32'h4B4B4B4B, 0);
      add_vec(32'h01020304, 1, 2'b00, 8'h00, 32'h01020304, 1);
      add_vec(32'h0A0B0C0D, 0, 2'b11, 8'h00, 32'h0A0B0C0D, 1);
      add_vec(32'hDEADBEEF, 0, 2'b11, 8'h00, 32'hDEADBEEF, 1);
      add_vec(32'h55555555, 1, 2'b11, 8'h00, 32'h00000000, 1);
      add_vec(32'h12345678, 0, 2'b11, 8'h00, 32'h00000000, 0);
      add_vec(32'h10203040, 1, 2'b10, 8'h00, 32'h10203040, 1);
      add_vec(32'h80808080, 1, 2'b10, 8'h00, 32'h80808080, 0);
      add_vec(32'h00000000, 0, 2'b10, 8'h00, 32'h60606060, 0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_out_sol", 32'(out_sol), 32'd0);
      check("reset_active_mode", 32'(active_mode), 32'd0);
      check("reset_mode_pending", 32'(mode_pending), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      begin
         exp_t e;
         in_data = 32'h11223344; in_sol = 1'b1; mode_req = 2'b00; in_valid = 1'b1;
         e.data = 32'h11223344; e.sol = 1'b1;
         sb.push_back(e);
         in_cnt++;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check("latency_cycle1_valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         check("latency_cycle2_valid", 32'(out_valid), 32'd1);
         check("latency_cycle2_data", out_data, 32'h11223344);
      end

      foreach (vecs[i]) send(vecs[i], $sformatf("run1_v%0d", i));
      drain("run1");
      check("run1_active_mode", 32'(active_mode), 32'd2);

      do_reset();
      bp_en = 1'b1;
      foreach (vecs[i]) send(vecs[i], $sformatf("bp_v%0d", i));
      drain("bp");
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      check("beat_count", 32'(out_cnt), 32'(in_cnt));

      in_data = 32'hAAAAAAAA; in_sol = 1'b1; mode_req = 2'b11; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_data = 32'hBBBBBBBB; in_sol = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("inflight_out_valid", 32'(out_valid), 32'd1);
      check("inflight_active_mode", 32'(active_mode), 32'd3);
      saved = out_cnt;
      n_rst = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_active_mode", 32'(active_mode), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("no_stale_beats", 32'(out_cnt), 32'(saved));
      check("post_rst_out_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
